// File: rtl/serial_router_p.sv
// serial_router_p
// Parametrised serial packet router. Deserialises an MSB-first framed
// bitstream (address field followed by payload field) and delivers the
// payload to one of NUM_PORTS output ports, each held under a ready/ack
// handshake until the consumer accepts it.
//
// Optional build macro: ROUTER_PARITY_EN
//   defined   - frames carry one trailing even-parity bit over addr+payload;
//               a parity mismatch raises frame_err and delivers nothing.
//   undefined - no parity bit, no parity logic.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in         serial data bit, MSB-first
//   rx_ready   frame-valid strobe, high while frame bits are presented
//   tx_ack     per-port consumer accept
//   dst        flattened payloads, port p at [p*DATA_W +: DATA_W]
//   tx_ready   per-port data-valid
//   frame_err  one-cycle pulse after a malformed frame closes
//   drop_cnt   saturating count of dropped well-formed frames
module serial_router_p #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in,
    input  logic                        rx_ready,
    input  logic [NUM_PORTS-1:0]        tx_ack,
    output logic [NUM_PORTS*DATA_W-1:0] dst,
    output logic [NUM_PORTS-1:0]        tx_ready,
    output logic                        frame_err,
    output logic [7:0]                  drop_cnt
);

`ifdef ROUTER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_LEN = ADDR_W + DATA_W + PAR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] sr;
    logic [CNT_W-1:0]     cnt;

    logic              closing;
    logic              len_ok;
    logic              parity_ok;
    logic              addr_ok;
    logic              busy;
    logic              deliver;
    logic              drop;
    logic              bad;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] payload;

    // Bits arrive MSB-first into the LSB, so the address sits at the top
    // of the shift register and the parity bit (if any) at the bottom.
    always_comb begin
        closing   = !rx_ready && (cnt != '0);
        len_ok    = (cnt == LEN_C);
        addr      = sr[FRAME_LEN-1 -: ADDR_W];
        payload   = sr[PAR_W +: DATA_W];
`ifdef ROUTER_PARITY_EN
        parity_ok = ~^sr;
`else
        parity_ok = 1'b1;
`endif
        addr_ok   = (32'(addr) < 32'(NUM_PORTS));
        busy      = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (32'(addr) == p) begin
                busy = tx_ready[p] && !tx_ack[p];
            end
        end
        deliver = closing && len_ok && parity_ok && addr_ok && !busy;
        drop    = closing && len_ok && parity_ok && (!addr_ok || busy);
        bad     = closing && !(len_ok && parity_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
            dst       <= '0;
            tx_ready  <= '0;
        end else begin
            frame_err <= bad;

            if (rx_ready) begin
                sr <= {sr[FRAME_LEN-2:0], in};
                if (cnt != MAX_C) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            // A delivery closing on the same edge as an ack wins: the new
            // payload loads and tx_ready stays high.
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (deliver && (32'(addr) == p)) begin
                    dst[p*DATA_W +: DATA_W] <= payload;
                    tx_ready[p]             <= 1'b1;
                end else if (tx_ready[p] && tx_ack[p]) begin
                    dst[p*DATA_W +: DATA_W] <= '0;
                    tx_ready[p]             <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_router_p.sv
module tb_serial_router_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        in;
    logic        rx_ready;
    logic        sel;
    logic [3:0]  tx_ack;
    logic [15:0] dst;
    logic [3:0]  tx_ready;
    logic        frame_err;
    logic [7:0]  drop_cnt;

    logic        rx_ready1;
    logic        rx_ready2;
    logic [2:0]  tx_ack2;
    logic [11:0] dst2;
    logic [2:0]  tx_ready2;
    logic        frame_err2;
    logic [7:0]  drop_cnt2;

    int compared   = 0;
    int mismatched = 0;

`ifdef ROUTER_PARITY_EN
    localparam int FL = 7;
`else
    localparam int FL = 6;
`endif

    assign rx_ready1 = rx_ready && !sel;
    assign rx_ready2 = rx_ready && sel;

    serial_router_p u_dut (
        .clk(clk), .rst(rst), .in(in), .rx_ready(rx_ready1), .tx_ack(tx_ack),
        .dst(dst), .tx_ready(tx_ready), .frame_err(frame_err), .drop_cnt(drop_cnt)
    );

    serial_router_p #(.NUM_PORTS(3), .ADDR_W(2), .DATA_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .in(in), .rx_ready(rx_ready2), .tx_ack(tx_ack2),
        .dst(dst2), .tx_ready(tx_ready2), .frame_err(frame_err2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    // Shifts n bits MSB-first, then applies the close edge with `in` high
    // (it must be ignored) and tx_ack = ack on that edge only.
    task automatic send_raw(input logic [31:0] bits, input int n, input logic [3:0] ack);
        for (int i = n - 1; i >= 0; i--) begin
            in       = bits[i];
            rx_ready = 1'b1;
            @(posedge clk); #1;
        end
        in       = 1'b1;
        rx_ready = 1'b0;
        tx_ack   = ack;
        @(posedge clk); #1;
        tx_ack   = '0;
        in       = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] a, input logic [3:0] d, input logic [3:0] ack);
        logic [31:0] b;
        b = {26'd0, a, d};
`ifdef ROUTER_PARITY_EN
        b = {b[30:0], ^b[5:0]};
`endif
        send_raw(b, FL, ack);
    endtask

    task automatic do_reset();
        rst = 1'b1; in = 1'b0; rx_ready = 1'b0; tx_ack = '0; tx_ack2 = '0; sel = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (tx_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_tx_ready: got %b expected 0000", tx_ready); end
        compared++; if (dst !== 16'h0000) begin mismatched++; $display("FAIL reset_dst: got %h expected 0000", dst); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        compared++; if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_deliver();
        send_frame(2'd2, 4'hA, 4'b0000);
        compared++; if (tx_ready !== 4'b0100) begin mismatched++; $display("FAIL deliver_tx_ready: got %b expected 0100", tx_ready); end
        compared++; if (dst !== 16'h0A00) begin mismatched++; $display("FAIL deliver_dst: got %h expected 0a00", dst); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL deliver_frame_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            compared++; if ({tx_ready, dst} !== {4'b0100, 16'h0A00}) begin mismatched++; $display("FAIL hold_cycle%0d: got %b/%h expected 0100/0a00", i, tx_ready, dst); end
        end
        tx_ack = 4'b0100;
        @(posedge clk); #1;
        tx_ack = '0;
        compared++; if (tx_ready !== 4'b0000) begin mismatched++; $display("FAIL ack_tx_ready: got %b expected 0000", tx_ready); end
        compared++; if (dst !== 16'h0000) begin mismatched++; $display("FAIL ack_dst: got %h expected 0000", dst); end
        // Ack on an idle port must be ignored.
        tx_ack = 4'b1000;
        @(posedge clk); #1;
        tx_ack = '0;
        compared++; if ({tx_ready, dst} !== 20'h0) begin mismatched++; $display("FAIL idle_ack: got %b/%h expected 0000/0000", tx_ready, dst); end
    endtask

    task automatic test_framing();
        send_raw(32'b1010, 4, 4'b0000);
        compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL short_frame_err: got %b expected 1", frame_err); end
        compared++; if (tx_ready !== 4'b0000) begin mismatched++; $display("FAIL short_tx_ready: got %b expected 0000", tx_ready); end
        @(posedge clk); #1;
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL short_pulse_width: got %b expected 0", frame_err); end
        send_raw(32'h1FF, FL + 1, 4'b0000);
        compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL long_frame_err: got %b expected 1", frame_err); end
        compared++; if (tx_ready !== 4'b0000) begin mismatched++; $display("FAIL long_tx_ready: got %b expected 0000", tx_ready); end
        @(posedge clk); #1;
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL long_pulse_width: got %b expected 0", frame_err); end
        compared++; if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL framing_drop_cnt: got %0d expected 0", drop_cnt); end
        // Reset part-way through a frame.
        for (int i = 0; i < 3; i++) begin
            in = 1'b1; rx_ready = 1'b1;
            @(posedge clk); #1;
        end
        rx_ready = 1'b0; in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL midreset_frame_err: got %b expected 0", frame_err); end
        send_frame(2'd0, 4'h5, 4'b0000);
        compared++; if (tx_ready !== 4'b0001) begin mismatched++; $display("FAIL midreset_tx_ready: got %b expected 0001", tx_ready); end
        compared++; if (dst !== 16'h0005) begin mismatched++; $display("FAIL midreset_dst: got %h expected 0005", dst); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL midreset_no_err: got %b expected 0", frame_err); end
        tx_ack = 4'b0001;
        @(posedge clk); #1;
        tx_ack = '0;
    endtask

    task automatic test_busy();
        send_frame(2'd1, 4'h3, 4'b0000);
        compared++; if ({tx_ready, dst} !== {4'b0010, 16'h0030}) begin mismatched++; $display("FAIL busy_first: got %b/%h expected 0010/0030", tx_ready, dst); end
        send_frame(2'd1, 4'h5, 4'b0000);
        compared++; if (drop_cnt !== 8'd1) begin mismatched++; $display("FAIL busy_drop_cnt: got %0d expected 1", drop_cnt); end
        compared++; if ({tx_ready, dst} !== {4'b0010, 16'h0030}) begin mismatched++; $display("FAIL busy_held: got %b/%h expected 0010/0030", tx_ready, dst); end
        // Ack on a different port does not free port 1.
        send_frame(2'd1, 4'h5, 4'b0001);
        compared++; if (drop_cnt !== 8'd2) begin mismatched++; $display("FAIL other_ack_drop_cnt: got %0d expected 2", drop_cnt); end
        send_frame(2'd1, 4'h5, 4'b0010);
        compared++; if ({tx_ready, dst} !== {4'b0010, 16'h0050}) begin mismatched++; $display("FAIL ack_replace: got %b/%h expected 0010/0050", tx_ready, dst); end
        compared++; if (drop_cnt !== 8'd2) begin mismatched++; $display("FAIL ack_replace_drop_cnt: got %0d expected 2", drop_cnt); end
    endtask

    task automatic test_bad_addr();
        sel = 1'b1;
        send_frame(2'd3, 4'h9, 4'b0000);
        compared++; if (tx_ready2 !== 3'b000) begin mismatched++; $display("FAIL badaddr_tx_ready: got %b expected 000", tx_ready2); end
        compared++; if (drop_cnt2 !== 8'd1) begin mismatched++; $display("FAIL badaddr_drop_cnt: got %0d expected 1", drop_cnt2); end
        compared++; if (frame_err2 !== 1'b0) begin mismatched++; $display("FAIL badaddr_frame_err: got %b expected 0", frame_err2); end
        for (int i = 1; i < 254; i++) send_frame(2'd3, 4'h9, 4'b0000);
        compared++; if (drop_cnt2 !== 8'd254) begin mismatched++; $display("FAIL badaddr_drop_254: got %0d expected 254", drop_cnt2); end
        for (int i = 254; i < 260; i++) send_frame(2'd3, 4'h9, 4'b0000);
        compared++; if (drop_cnt2 !== 8'd255) begin mismatched++; $display("FAIL badaddr_saturate: got %0d expected 255", drop_cnt2); end
        compared++; if ({tx_ready2, dst2} !== 15'h0) begin mismatched++; $display("FAIL badaddr_outputs: got %b/%h expected 000/000", tx_ready2, dst2); end
        sel = 1'b0;
    endtask

`ifdef ROUTER_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_raw(32'b1010101, 7, 4'b0000);
        compared++; if ({tx_ready, dst} !== {4'b0100, 16'h0A00}) begin mismatched++; $display("FAIL parity_good: got %b/%h expected 0100/0a00", tx_ready, dst); end
        tx_ack = 4'b0100;
        @(posedge clk); #1;
        tx_ack = '0;
        send_raw(32'b1010100, 7, 4'b0000);
        compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL parity_bad_err: got %b expected 1", frame_err); end
        compared++; if ({tx_ready, dst} !== 20'h0) begin mismatched++; $display("FAIL parity_bad_deliver: got %b/%h expected 0000/0000", tx_ready, dst); end
        compared++; if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL parity_bad_drop_cnt: got %0d expected 0", drop_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_deliver();
        test_hold();
        test_framing();
        test_busy();
        test_bad_addr();
`ifdef ROUTER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
